// File: rtl/dff_share_arbiter.sv
// dff_share_arbiter
// One WIDTH-bit D register shared by NREQ requesters. A round-robin arbiter
// hands out exclusive write ownership. Each ownership lasts at most HOLD_MAX
// GRANT cycles, and every ownership is followed by a RELEASE/IDLE gap so
// that two grants never overlap.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no owner; arbitrate round-robin from last+1 when any req is set
//   GRANT   | owner holds the register; its loads update q; hold counter runs
//   RELEASE | one dead cycle; remember owner as last, then return to IDLE
module dff_share_arbiter #(
  parameter  int NREQ     = 4,
  parameter  int WIDTH    = 8,
  parameter  int HOLD_MAX = 15,
  localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       load,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [OW-1:0]         owner,
  output logic [WIDTH-1:0]      q,
  output logic                  busy,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // Hold counter counts up from 0; expiry is the cycle it sits at HOLD_MAX-1,
  // so an ownership spans exactly HOLD_MAX GRANT cycles.
  localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

  state_t            state, state_nxt;
  logic [NREQ-1:0]   gnt_nxt;
  logic [OW-1:0]     owner_nxt;
  logic [WIDTH-1:0]  q_nxt;
  logic              busy_nxt;
  logic              timeout_nxt;
  logic [7:0]        cnt, cnt_nxt;
  logic [OW-1:0]     last, last_nxt;

  logic              win_found;
  logic [OW-1:0]     win_idx;
  logic [OW-1:0]     cand;
  logic [NREQ-1:0]   win_onehot;
  logic [WIDTH-1:0]  sel_din;
  logic              req_own;
  logic              load_own;

  // Round-robin search: the first asserted req starting at last+1, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = OW'((int'(last) + k) % NREQ);
      for (int j = 0; j < NREQ; j++) begin
        if (!win_found && req[j] && (cand == OW'(j))) begin
          win_found = 1'b1;
          win_idx   = cand;
        end
      end
    end
  end

  // One-hot decode of the winner, and the owner's data slice.
  always_comb begin
    win_onehot = '0;
    sel_din    = '0;
    for (int j = 0; j < NREQ; j++) begin
      win_onehot[j] = (win_idx == OW'(j));
      if (owner == OW'(j)) begin
        sel_din = din[j*WIDTH +: WIDTH];
      end
    end
  end

  // gnt is one-hot on owner throughout GRANT, so masking with it picks the
  // owner's req/load bits without another index decode.
  assign req_own  = |(req & gnt);
  assign load_own = |(load & gnt);

  // Next-state and next-output logic.
  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    owner_nxt   = owner;
    q_nxt       = q;
    busy_nxt    = busy;
    timeout_nxt = 1'b0;
    cnt_nxt     = cnt;
    last_nxt    = last;
    case (state)
      IDLE: begin
        gnt_nxt  = '0;
        busy_nxt = 1'b0;
        if (win_found) begin
          state_nxt = GRANT;
          gnt_nxt   = win_onehot;
          owner_nxt = win_idx;
          busy_nxt  = 1'b1;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        if (!req_own) begin
          // Voluntary release wins over expiry, and a load issued in this
          // cycle is dropped.
          state_nxt = RELEASE;
          gnt_nxt   = '0;
          busy_nxt  = 1'b0;
        end else begin
          if (load_own) begin
            q_nxt = sel_din;
          end
          if (cnt == CNT_LAST) begin
            state_nxt   = RELEASE;
            gnt_nxt     = '0;
            busy_nxt    = 1'b0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      RELEASE: begin
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
        last_nxt  = owner;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and registered outputs. Reset leaves last at NREQ-1 so that
  // requester 0 has first priority after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      q       <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      cnt     <= '0;
      last    <= OW'(NREQ - 1);
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      owner   <= owner_nxt;
      q       <= q_nxt;
      busy    <= busy_nxt;
      timeout <= timeout_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
    end
  end

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed bench for dff_share_arbiter (NREQ=4, WIDTH=8, HOLD_MAX=4).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_dff_share_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  load;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [7:0]  q;
  logic        busy;
  logic        timeout;

  int n_chk = 0;
  int n_err = 0;
  int seq[5] = '{0, 1, 2, 3, 0};

  dff_share_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .load(load), .din(din),
    .gnt(gnt), .owner(owner), .q(q), .busy(busy), .timeout(timeout)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eg, input logic eb,
                         input logic et, input logic [7:0] eq);
    chk({tag, ".gnt"},     32'(gnt),       32'(eg));
    chk({tag, ".busy"},    32'(busy),      32'(eb));
    chk({tag, ".timeout"}, 32'(timeout),   32'(et));
    chk({tag, ".q"},       32'(q),         32'(eq));
    chk({tag, ".onehot"},  32'($onehot0(gnt)), 32'd1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst  = 1'b0;
    req  = '0;
    load = '0;
    din  = '0;

    // Reset held 100 ns with random activity on the inputs.
    for (int i = 0; i < 10; i++) begin
      req  = 4'($urandom);
      load = 4'($urandom);
      din  = $urandom;
      step();
      chk_out($sformatf("rst%0d", i), 4'b0000, 1'b0, 1'b0, 8'h00);
    end
    chk("rst.owner", 32'(owner), 32'd0);
    req = '0; load = '0; din = '0;
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_out("idle", 4'b0000, 1'b0, 1'b0, 8'h00);

    // Single write by requester 0.
    req = 4'b0001; load = 4'b0001; din[7:0] = 8'hA5;
    step();
    chk_out("wr_gnt", 4'b0001, 1'b1, 1'b0, 8'h00);
    chk("wr_gnt.owner", 32'(owner), 32'd0);
    step();
    chk_out("wr_q", 4'b0001, 1'b1, 1'b0, 8'hA5);
    req = '0; load = '0;
    step();
    chk_out("wr_rel", 4'b0000, 1'b0, 1'b0, 8'hA5);
    step();
    chk_out("wr_idle", 4'b0000, 1'b0, 1'b0, 8'hA5);

    // Reset again so requester 0 is first, then round-robin with all requesting.
    rst = 1'b0;
    #1;
    chk_out("rr_rst", 4'b0000, 1'b0, 1'b0, 8'h00);
    req = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < HOLD_MAX; c++) begin
        step();
        chk_out($sformatf("rr%0d_g%0d", s, c), 4'(1 << seq[s]), 1'b1, 1'b0, 8'h00);
        chk($sformatf("rr%0d_g%0d.owner", s, c), 32'(owner), 32'(seq[s]));
      end
      step();
      chk_out($sformatf("rr%0d_rel", s), 4'b0000, 1'b0, 1'b1, 8'h00);
      step();
      chk_out($sformatf("rr%0d_gap", s), 4'b0000, 1'b0, 1'b0, 8'h00);
    end
    req = '0;
    step();
    chk_out("rr_end", 4'b0000, 1'b0, 1'b0, 8'h00);

    // Isolation: owner 2, non-owner loads ignored.
    req = 4'b0100; load = 4'b0000;
    step();
    chk_out("iso_g", 4'b0100, 1'b1, 1'b0, 8'h00);
    chk("iso_g.owner", 32'(owner), 32'd2);
    load = 4'b1011; din = {8'hFF, 8'h3C, 8'hFF, 8'hFF};
    step();
    chk_out("iso_hold", 4'b0100, 1'b1, 1'b0, 8'h00);
    load = 4'b0100;
    step();
    chk_out("iso_ld", 4'b0100, 1'b1, 1'b0, 8'h3C);
    req = '0; load = '0;
    step();
    chk_out("iso_rel", 4'b0000, 1'b0, 1'b0, 8'h3C);
    step();
    chk_out("iso_idle", 4'b0000, 1'b0, 1'b0, 8'h3C);

    // Coincidence: requester 3 drops req in its last hold cycle, with a load.
    req = 4'b1000; load = '0; din = 32'h7777_7777;
    for (int c = 0; c < HOLD_MAX; c++) begin
      step();
      chk_out($sformatf("coin_g%0d", c), 4'b1000, 1'b1, 1'b0, 8'h3C);
    end
    req = '0; load = 4'b1000;
    step();
    chk_out("coin_rel", 4'b0000, 1'b0, 1'b0, 8'h3C);
    load = '0;
    step();
    chk_out("coin_idle", 4'b0000, 1'b0, 1'b0, 8'h3C);

    // Load in the expiry cycle still lands in q.
    req = 4'b0001; din[7:0] = 8'h81;
    for (int c = 0; c < HOLD_MAX; c++) begin
      step();
      chk_out($sformatf("exp_g%0d", c), 4'b0001, 1'b1, 1'b0, 8'h3C);
    end
    load = 4'b0001;
    step();
    chk_out("exp_ld", 4'b0000, 1'b0, 1'b1, 8'h81);
    req = '0; load = '0;
    step();
    chk_out("exp_idle", 4'b0000, 1'b0, 1'b0, 8'h81);

    // Reset in the middle of a GRANT.
    req = 4'b0010; load = 4'b0010; din[15:8] = 8'h5A;
    step();
    chk_out("rm_g", 4'b0010, 1'b1, 1'b0, 8'h81);
    step();
    chk_out("rm_q", 4'b0010, 1'b1, 1'b0, 8'h5A);
    #2;
    rst = 1'b0;
    #1;
    chk_out("rm_async", 4'b0000, 1'b0, 1'b0, 8'h00);
    req = 4'b0100; load = '0;
    step();
    chk_out("rm_hold", 4'b0000, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk_out("rm_post", 4'b0100, 1'b1, 1'b0, 8'h00);
    chk("rm_post.owner", 32'(owner), 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
